// File: rtl/dac_interface_pkg.sv
// Shared constants, state encoding and helpers for the TX DAC interface.
package dac_interface_pkg;

    localparam logic [6:0] FR_TX_MUX       = 7'd39;
    localparam logic [6:0] FR_DAC_OFFSET_0 = 7'd10;
    localparam logic [6:0] FR_DAC_OFFSET_1 = 7'd11;
    localparam logic [6:0] FR_DAC_OFFSET_2 = 7'd12;
    localparam logic [6:0] FR_DAC_OFFSET_3 = 7'd13;

    localparam int NUM_DACS    = 4;
    localparam int NIB_WIDTH   = 4;
    localparam int NIB_EN_BIT  = 3;
    localparam int NUMCHAN_LSB = 16;
    localparam int MUX_WIDTH   = 20;
    localparam int OFFSET_WIDTH = 16;

    localparam logic [2:0] SRC_TX0_I = 3'd0;
    localparam logic [2:0] SRC_TX0_Q = 3'd1;
    localparam logic [2:0] SRC_TX1_I = 3'd2;
    localparam logic [2:0] SRC_TX1_Q = 3'd3;

    localparam logic [8:0] GAIN_UNITY = 9'd256;
    localparam logic [8:0] GAIN_TOP   = 9'd255;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RUN       = 2'd2,
        RAMP_DOWN = 2'd3
    } ramp_state_t;

    function automatic logic [NIB_WIDTH-1:0] mux_nibble(input logic [MUX_WIDTH-1:0] mux,
                                                        input int idx);
        return mux[NIB_WIDTH*idx +: NIB_WIDTH];
    endfunction

    // Clamp a 17-bit sum to 16 bits and keep the top 14 bits for the DAC pins.
    function automatic logic [13:0] dac_word(input logic signed [16:0] value);
        if (value[16] != value[15])
            return value[16] ? 14'h2000 : 14'h1FFF;
        return value[15:2];
    endfunction

endpackage

// File: rtl/dac_ramp_ctl.sv
// Soft-start / soft-stop gain ramp: gain walks 0..256 while enabled, back to 0 when not.
module dac_ramp_ctl
    import dac_interface_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    output logic [8:0] gain,
    output logic       tx_active
);

    ramp_state_t state;
    ramp_state_t state_next;
    logic [8:0]  gain_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            gain      <= '0;
            tx_active <= 1'b0;
        end else begin
            state     <= state_next;
            gain      <= gain_next;
            tx_active <= (state_next != IDLE);
        end
    end

    // A direction change holds the gain for one clock, so the ramp reverses without a jump.
    always_comb begin
        state_next = state;
        gain_next  = gain;
        case (state)
            IDLE: begin
                gain_next = '0;
                if (enable)
                    state_next = RAMP_UP;
            end
            RAMP_UP: begin
                if (!enable) begin
                    state_next = RAMP_DOWN;
                end else if (gain >= GAIN_TOP) begin
                    state_next = RUN;
                    gain_next  = GAIN_UNITY;
                end else begin
                    gain_next = gain + 9'd1;
                end
            end
            RUN: begin
                gain_next = GAIN_UNITY;
                if (!enable)
                    state_next = RAMP_DOWN;
            end
            RAMP_DOWN: begin
                if (enable) begin
                    state_next = RAMP_UP;
                end else if (gain <= 9'd1) begin
                    state_next = IDLE;
                    gain_next  = '0;
                end else begin
                    gain_next = gain - 9'd1;
                end
            end
            default: begin
                state_next = IDLE;
                gain_next  = '0;
            end
        endcase
    end

endmodule

// File: rtl/setting_reg.sv
// Settings-bus register: captures serial data when its address is strobed.
module setting_reg #(
    parameter logic [6:0] ADDR  = 7'd0,
    parameter int         WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             strobe,
    input  logic [6:0]       addr,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    always_ff @(posedge clock) begin
        if (reset)
            out <= '0;
        else if (strobe && addr == ADDR)
            out <= in;
    end

endmodule

// File: rtl/dac_interface.sv
// TX DAC front end: programmable source mux, gain ramp, DC offset and saturation
// into registered 14-bit AD9862 DAC words.
module dac_interface
    import dac_interface_pkg::*;
#(
    parameter logic [6:0] MUX_ADDR     = FR_TX_MUX,
    parameter logic [6:0] OFFSET_ADDR0 = FR_DAC_OFFSET_0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic [6:0]         serial_addr,
    input  logic [31:0]        serial_data,
    input  logic               serial_strobe,
    input  logic signed [15:0] tx0_i,
    input  logic signed [15:0] tx0_q,
    input  logic signed [15:0] tx1_i,
    input  logic signed [15:0] tx1_q,
    output logic [13:0]        tx_a_a,
    output logic [13:0]        tx_b_a,
    output logic [13:0]        tx_a_b,
    output logic [13:0]        tx_b_b,
    output logic [3:0]         tx_numchan,
    output logic               tx_active
);

    logic [MUX_WIDTH-1:0]    mux_reg;
    logic [OFFSET_WIDTH-1:0] offset_reg [NUM_DACS];
    logic [8:0]              gain;

    logic signed [15:0] samples  [NUM_DACS];
    logic [3:0]         nib      [NUM_DACS];
    logic signed [15:0] selected [NUM_DACS];
    logic signed [23:0] product  [NUM_DACS];
    logic signed [16:0] sum      [NUM_DACS];
    logic [13:0]        word     [NUM_DACS];

    logic signed [15:0] s1   [NUM_DACS];
    logic signed [15:0] prod [NUM_DACS];
    logic [13:0]        dac  [NUM_DACS];
    logic               unused_bits;

    setting_reg #(.ADDR(MUX_ADDR), .WIDTH(MUX_WIDTH)) mux_setting (
        .clock  (clock),
        .reset  (reset),
        .strobe (serial_strobe),
        .addr   (serial_addr),
        .in     (serial_data[MUX_WIDTH-1:0]),
        .out    (mux_reg)
    );

    for (genvar d = 0; d < NUM_DACS; d++) begin : g_offset
        setting_reg #(.ADDR(OFFSET_ADDR0 + 7'(d)), .WIDTH(OFFSET_WIDTH)) offset_setting (
            .clock  (clock),
            .reset  (reset),
            .strobe (serial_strobe),
            .addr   (serial_addr),
            .in     (serial_data[OFFSET_WIDTH-1:0]),
            .out    (offset_reg[d])
        );
    end

    dac_ramp_ctl ramp (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .gain      (gain),
        .tx_active (tx_active)
    );

    // Product is at most 2^23 in magnitude, so 24 bits hold it; bits [23:8] are the floor-shifted result.
    always_comb begin
        samples[0]  = tx0_i;
        samples[1]  = tx0_q;
        samples[2]  = tx1_i;
        samples[3]  = tx1_q;
        unused_bits = ^serial_data[31:MUX_WIDTH];
        for (int d = 0; d < NUM_DACS; d++) begin
            nib[d]      = mux_nibble(mux_reg, d);
            selected[d] = '0;
            if (nib[d][NIB_EN_BIT] && !nib[d][2])
                selected[d] = samples[nib[d][1:0]];
            product[d]  = s1[d] * $signed({1'b0, gain});
            sum[d]      = {prod[d][15], prod[d]} + {offset_reg[d][15], offset_reg[d]};
            word[d]     = dac_word(sum[d]);
            unused_bits = unused_bits ^ (^product[d][7:0]) ^ (^sum[d][1:0]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int d = 0; d < NUM_DACS; d++) begin
                s1[d]   <= '0;
                prod[d] <= '0;
                dac[d]  <= '0;
            end
        end else begin
            for (int d = 0; d < NUM_DACS; d++) begin
                s1[d]   <= selected[d];
                prod[d] <= product[d][23:8];
                dac[d]  <= word[d];
            end
        end
    end

    assign tx_a_a     = dac[0];
    assign tx_b_a     = dac[1];
    assign tx_a_b     = dac[2];
    assign tx_b_b     = dac[3];
    assign tx_numchan = mux_reg[NUMCHAN_LSB +: 4];

endmodule

// File: tb/tb_dac_interface.sv
// Bench for dac_interface: integer reference model compared every cycle plus
// hand-computed checkpoints through ramp, clipping, reversal and reset scenarios.
module tb_dac_interface;
    import dac_interface_pkg::*;

    logic               clock = 1'b0;
    logic               reset;
    logic               enable;
    logic [6:0]         serial_addr;
    logic [31:0]        serial_data;
    logic               serial_strobe;
    logic signed [15:0] tx0_i, tx0_q, tx1_i, tx1_q;
    logic [13:0]        tx_a_a, tx_b_a, tx_a_b, tx_b_b;
    logic [3:0]         tx_numchan;
    logic               tx_active;

    int compared   = 0;
    int mismatched = 0;

    always #5 clock = ~clock;

    dac_interface dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .serial_addr   (serial_addr),
        .serial_data   (serial_data),
        .serial_strobe (serial_strobe),
        .tx0_i         (tx0_i),
        .tx0_q         (tx0_q),
        .tx1_i         (tx1_i),
        .tx1_q         (tx1_q),
        .tx_a_a        (tx_a_a),
        .tx_b_a        (tx_b_a),
        .tx_a_b        (tx_a_b),
        .tx_b_b        (tx_b_b),
        .tx_numchan    (tx_numchan),
        .tx_active     (tx_active)
    );

    logic [31:0] m_mux;
    int          m_off  [4];
    int          m_s1   [4];
    int          m_prod [4];
    int          m_dac  [4];
    int          in_s   [4];
    int          m_gain;
    bit          m_active;
    bit          m_up;
    bit          model_valid = 1'b0;

    function automatic int pick(input logic [3:0] nib, input int s0, input int s1,
                                input int s2, input int s3);
        if (!nib[3] || nib[2]) return 0;
        case (nib[1:0])
            2'd0:    return s0;
            2'd1:    return s1;
            2'd2:    return s2;
            default: return s3;
        endcase
    endfunction

    function automatic int expect_word(input int v);
        if (v > 32767)  v = 32767;
        if (v < -32768) v = -32768;
        return (v >>> 2) & 'h3FFF;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: each clock, pipeline stages consume the values held before the edge.
    always @(posedge clock) begin
        if (reset) begin
            m_mux = '0;
            for (int d = 0; d < 4; d++) begin
                m_off[d] = 0; m_s1[d] = 0; m_prod[d] = 0; m_dac[d] = 0;
            end
            m_gain      = 0;
            m_active    = 1'b0;
            m_up        = 1'b0;
            model_valid = 1'b1;
        end else begin
            in_s[0] = int'(tx0_i); in_s[1] = int'(tx0_q);
            in_s[2] = int'(tx1_i); in_s[3] = int'(tx1_q);
            for (int d = 0; d < 4; d++) begin
                m_dac[d]  = expect_word(m_prod[d] + m_off[d]);
                m_prod[d] = (m_s1[d] * m_gain) >>> 8;
                m_s1[d]   = pick(m_mux[4*d +: 4], in_s[0], in_s[1], in_s[2], in_s[3]);
            end
            if (!m_active) begin
                m_gain = 0;
                if (enable) begin
                    m_active = 1'b1;
                    m_up     = 1'b1;
                end
            end else if (enable != m_up) begin
                m_up = enable;
            end else if (m_up) begin
                m_gain = (m_gain >= 255) ? 256 : m_gain + 1;
            end else if (m_gain <= 1) begin
                m_gain   = 0;
                m_active = 1'b0;
            end else begin
                m_gain = m_gain - 1;
            end
            if (serial_strobe) begin
                if (serial_addr == FR_TX_MUX) m_mux = serial_data;
                for (int d = 0; d < 4; d++)
                    if (serial_addr == FR_DAC_OFFSET_0 + 7'(d))
                        m_off[d] = int'($signed(serial_data[15:0]));
            end
        end
    end

    always @(negedge clock) begin
        if (model_valid) begin
            checkOutput("tx_a_a", int'(tx_a_a), m_dac[0]);
            checkOutput("tx_b_a", int'(tx_b_a), m_dac[1]);
            checkOutput("tx_a_b", int'(tx_a_b), m_dac[2]);
            checkOutput("tx_b_b", int'(tx_b_b), m_dac[3]);
            checkOutput("tx_numchan", int'(tx_numchan), int'(m_mux[19:16]));
            checkOutput("tx_active", int'(tx_active), int'(m_active));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] c, input logic [15:0] d);
        tx0_i = a; tx0_q = b; tx1_i = c; tx1_q = d;
    endtask

    task automatic write_reg(input logic [6:0] addr, input logic [31:0] data);
        serial_addr   = addr;
        serial_data   = data;
        serial_strobe = 1'b1;
        tick();
        serial_strobe = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0;
        serial_addr = '0; serial_data = '0; serial_strobe = 1'b0;
        applyStimulus(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        tick(); tick();
        reset = 1'b0;

        // Idle after reset: random inputs must not reach the pins.
        repeat (6) begin
            applyStimulus(16'($urandom()), 16'($urandom()), 16'($urandom()), 16'($urandom()));
            tick();
        end
        checkOutput("lit_reset_a_a", int'(tx_a_a), 0);
        checkOutput("lit_reset_b_b", int'(tx_b_b), 0);
        checkOutput("lit_reset_active", int'(tx_active), 0);
        checkOutput("lit_reset_numchan", int'(tx_numchan), 0);

        // Ramp-up to unity.
        applyStimulus(16'h4000, 16'h1234, 16'hC000, 16'h0010);
        write_reg(FR_TX_MUX, 32'h0003_BA98);
        checkOutput("lit_numchan", int'(tx_numchan), 3);
        enable = 1'b1;
        tick();
        checkOutput("lit_active_t0", int'(tx_active), 1);
        repeat (130) tick();
        checkOutput("lit_half_gain", int'(tx_a_a), 'h0800);
        repeat (128) tick();
        checkOutput("lit_unity_a_a", int'(tx_a_a), 'h1000);
        checkOutput("lit_unity_b_a", int'(tx_b_a), 'h048D);
        checkOutput("lit_unity_a_b", int'(tx_a_b), 'h3000);

        // Saturation in both directions.
        write_reg(FR_DAC_OFFSET_0, 32'h0000_7000);
        repeat (4) tick();
        checkOutput("lit_pos_clip", int'(tx_a_a), 'h1FFF);
        write_reg(FR_DAC_OFFSET_0, 32'hFFFF_8000);
        applyStimulus(16'h8000, 16'h1234, 16'hC000, 16'h0010);
        repeat (4) tick();
        checkOutput("lit_neg_clip", int'(tx_a_a), 'h2000);

        // Full ramp down, then an interrupted ramp-up.
        enable = 1'b0;
        write_reg(FR_DAC_OFFSET_0, 32'h0000_0100);
        applyStimulus(16'h4000, 16'h1234, 16'hC000, 16'h0010);
        repeat (300) tick();
        checkOutput("lit_idle_active", int'(tx_active), 0);
        checkOutput("lit_idle_offset", int'(tx_a_a), 'h0040);
        enable = 1'b1;
        tick();
        repeat (100) tick();
        enable = 1'b0;
        repeat (100) tick();
        checkOutput("lit_down_active", int'(tx_active), 1);
        tick();
        checkOutput("lit_down_idle", int'(tx_active), 0);
        repeat (3) tick();
        checkOutput("lit_down_offset", int'(tx_a_a), 'h0040);

        // Reverse back up from gain 40 while ramping down.
        enable = 1'b1;
        tick();
        repeat (60) tick();
        enable = 1'b0;
        repeat (21) tick();
        enable = 1'b1;
        repeat (3) tick();
        checkOutput("lit_rev_hold", int'(tx_a_a), 'h02C0);
        repeat (2) tick();
        checkOutput("lit_rev_rise", int'(tx_a_a), 'h02E0);

        // Disabled nibble and out-of-range source both select zero.
        write_reg(FR_TX_MUX, 32'h0003_BA90);
        applyStimulus(16'h7ABC, 16'h1234, 16'hC000, 16'h0010);
        repeat (4) tick();
        checkOutput("lit_nib_off", int'(tx_a_a), 'h0040);
        write_reg(FR_TX_MUX, 32'h0003_BA9D);
        applyStimulus(16'h8001, 16'h5555, 16'hC000, 16'h0010);
        repeat (4) tick();
        checkOutput("lit_nib_src5", int'(tx_a_a), 'h0040);

        // Reset while running.
        write_reg(FR_TX_MUX, 32'h0003_BA98);
        repeat (300) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("lit_rst_run_a_a", int'(tx_a_a), 0);
        checkOutput("lit_rst_run_b_a", int'(tx_b_a), 0);
        checkOutput("lit_rst_run_active", int'(tx_active), 0);
        checkOutput("lit_rst_run_numchan", int'(tx_numchan), 0);
        tick();
        checkOutput("lit_restart_active", int'(tx_active), 1);
        repeat (5) tick();
        checkOutput("lit_restart_a_a", int'(tx_a_a), 0);
        checkOutput("lit_restart_b_a", int'(tx_b_a), 0);

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
